// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared hazard command codes, PC-source selects, stage ids and FSM states.
package hazard_ctrl_pkg;
    typedef enum logic [3:0] {
        HZ_NONE         = 4'd0,
        HZ_STALL_EARLY  = 4'd1,
        HZ_FLUSH_EARLY  = 4'd2,
        HZ_FLUSH_ALL    = 4'd3,
        HZ_FLUSH_EXCEPT = 4'd4,
        HZ_STALL_MMU    = 4'd5
    } hazard_e;
    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_TRAP   = 2'd2,
        PC_SERIAL = 2'd3
    } pc_sel_e;
    typedef enum logic [2:0] {
        STAGE_IF  = 3'd0,
        STAGE_ID  = 3'd1,
        STAGE_EX  = 3'd2,
        STAGE_MEM = 3'd3,
        STAGE_WB  = 3'd4
    } stage_e;
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MMU_WAIT   = 2'd1,
        ST_TRAP_FLUSH = 2'd2
    } state_e;
endpackage

// File: rtl/hazard_ctrl_perf_counter.sv
// hazard_perf_counter: saturating event counter, only built when HAZARD_PERF_EN is defined.
`ifdef HAZARD_PERF_EN
module hazard_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
    assign cnt_o = cnt_q;
endmodule
`endif

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard/flush arbiter driving the stage command bus and fetch PC control.
// Optional stall/flush performance counters are enabled by HAZARD_PERF_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W        = 5,
    parameter int TRAP_FLUSH_CYCLES = 2,
    parameter int PERF_W            = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  br_redirect,
    input  logic                  csr_serialize,
    input  logic                  trap_req,
    input  logic                  mmu_busy,
    input  logic                  mmu_done,
    output logic [3:0]            hazard_signal,
    output logic                  pc_stall,
    output logic [1:0]            pc_sel,
    output logic                  trap_pending,
    output logic [PERF_W-1:0]     perf_stall_cnt,
    output logic [PERF_W-1:0]     perf_flush_cnt
);
    localparam logic [3:0] CNT_INIT = 4'(TRAP_FLUSH_CYCLES - 1);
    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    hazard_e    hz;
    pc_sel_e    sel;
    logic       stall;
    logic       take_trap;
    logic       load_use;
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        hz        = HZ_NONE;
        sel       = PC_SEQ;
        stall     = 1'b0;
        take_trap = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (trap_req) take_trap = 1'b1;
                else if (mmu_busy) begin
                    hz      = HZ_STALL_MMU;
                    stall   = 1'b1;
                    state_d = ST_MMU_WAIT;
                end else if (csr_serialize) begin
                    hz  = HZ_FLUSH_ALL;
                    sel = PC_SERIAL;
                end else if (br_redirect) begin
                    hz  = HZ_FLUSH_EARLY;
                    sel = PC_BRANCH;
                end else if (load_use) begin
                    hz    = HZ_STALL_EARLY;
                    stall = 1'b1;
                end
            end
            ST_MMU_WAIT: begin
                if (mmu_done) begin
                    take_trap = pend_q || trap_req;
                    state_d   = ST_RUN;
                end else begin
                    hz     = HZ_STALL_MMU;
                    stall  = 1'b1;
                    pend_d = pend_q || trap_req;
                end
            end
            ST_TRAP_FLUSH: begin
                hz      = HZ_FLUSH_EXCEPT;
                stall   = 1'b1;
                cnt_d   = trap_req ? CNT_INIT : cnt_q - 4'd1;
                state_d = (cnt_d == 4'd0) ? ST_RUN : ST_TRAP_FLUSH;
            end
            default: state_d = ST_RUN;
        endcase
        // Trap entry is shared by RUN and the end of an MMU walk.
        if (take_trap) begin
            hz      = HZ_FLUSH_EXCEPT;
            sel     = PC_TRAP;
            cnt_d   = CNT_INIT;
            pend_d  = 1'b0;
            state_d = (CNT_INIT == 4'd0) ? ST_RUN : ST_TRAP_FLUSH;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end
    assign hazard_signal = rst ? HZ_NONE : hz;
    assign pc_stall      = !rst && stall;
    assign pc_sel        = rst ? PC_SEQ : sel;
    assign trap_pending  = pend_q;
`ifdef HAZARD_PERF_EN
    logic stall_ev, flush_ev;
    assign stall_ev = hazard_signal == HZ_STALL_EARLY || hazard_signal == HZ_STALL_MMU;
    assign flush_ev = hazard_signal == HZ_FLUSH_EARLY || hazard_signal == HZ_FLUSH_ALL ||
                      hazard_signal == HZ_FLUSH_EXCEPT;
    hazard_perf_counter #(.W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_ev),
        .cnt_o (perf_stall_cnt)
    );
    hazard_perf_counter #(.W(PERF_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush_ev),
        .cnt_o (perf_flush_cnt)
    );
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus random stimulus against a behavioural model, checked through a scoreboard queue.
module tb_hazard_ctrl;
    localparam int TFC = 2;
    typedef struct {
        logic [3:0]  hz;
        logic        st;
        logic [1:0]  sel;
        logic        tp;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, br_redirect = 0;
    logic csr_serialize = 0, trap_req = 0, mmu_busy = 0, mmu_done = 0;
    logic [3:0]  hazard_signal;
    logic        pc_stall, trap_pending;
    logic [1:0]  pc_sel;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    // Model state: remaining flush cycles after the current one, walk in progress, latched trap, event counts.
    int flush_left = 0;
    bit in_walk = 0, pend = 0;
    int n_stall = 0, n_flush = 0;

    hazard_ctrl #(.REG_ADDR_W(5), .TRAP_FLUSH_CYCLES(TFC), .PERF_W(32)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .br_redirect(br_redirect), .csr_serialize(csr_serialize),
        .trap_req(trap_req), .mmu_busy(mmu_busy), .mmu_done(mmu_done),
        .hazard_signal(hazard_signal), .pc_stall(pc_stall), .pc_sel(pc_sel),
        .trap_pending(trap_pending), .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic r, tr, busy, done, csr, br, mr,
                       input logic [4:0] rd, r1, r2, input logic u1, u2);
        exp_t e;
        bit lu;
        @(negedge clk);
        rst = r; trap_req = tr; mmu_busy = busy; mmu_done = done; csr_serialize = csr;
        br_redirect = br; ex_mem_read = mr; ex_rd = rd; id_rs1 = r1; id_rs2 = r2;
        id_use_rs1 = u1; id_use_rs2 = u2;
        #1;
        e.tp = pend;
`ifdef HAZARD_PERF_EN
        e.ps = n_stall; e.pf = n_flush;
`else
        e.ps = 0; e.pf = 0;
`endif
        e.hz = 0; e.st = 0; e.sel = 0;
        lu = mr && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
        if (r) begin
            flush_left = 0; in_walk = 0; pend = 0;
        end else if (flush_left > 0) begin
            e.hz = 4; e.st = 1;
            flush_left = tr ? TFC - 1 : flush_left - 1;
        end else if (in_walk) begin
            if (done) begin
                in_walk = 0;
                if (pend || tr) begin
                    e.hz = 4; e.sel = 2; pend = 0; flush_left = TFC - 1;
                end
            end else begin
                e.hz = 5; e.st = 1; pend = pend | tr;
            end
        end else if (tr) begin
            e.hz = 4; e.sel = 2; flush_left = TFC - 1;
        end else if (busy) begin
            e.hz = 5; e.st = 1; in_walk = 1;
        end else if (csr) begin
            e.hz = 3; e.sel = 3;
        end else if (br) begin
            e.hz = 2; e.sel = 1;
        end else if (lu) begin
            e.hz = 1; e.st = 1;
        end
        if (r) begin
            n_stall = 0; n_flush = 0;
        end else begin
            if (e.hz == 1 || e.hz == 5) n_stall++;
            if (e.hz >= 2 && e.hz <= 4) n_flush++;
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, wanted %0h (vector %0d)", name, act, req, vectors);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                chk("hazard_signal", 32'(hazard_signal), 32'(e.hz));
                chk("pc_stall", 32'(pc_stall), 32'(e.st));
                chk("pc_sel", 32'(pc_sel), 32'(e.sel));
                chk("trap_pending", 32'(trap_pending), 32'(e.tp));
                chk("perf_stall_cnt", perf_stall_cnt, e.ps);
                chk("perf_flush_cnt", perf_flush_cnt, e.pf);
            end
        end
    end

    initial begin : driver
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        // load-use, then same stimulus with x0 destination
        cyc(0, 0, 0, 0, 0, 0, 1, 5, 5, 0, 1, 0);
        idle(1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 1, 7, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 1, 7, 0, 1);
        // redirect beats load-use
        cyc(0, 0, 0, 0, 0, 1, 1, 5, 5, 0, 1, 0);
        // trap pulse in RUN
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // MMU walk with trap latched mid-walk
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // walk without trap, and trap coincident with done
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // serialise beats redirect; stray done ignored
        cyc(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // trap restart during flush
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        // ten load-use stalls plus a trap, then reset mid-walk with pending trap
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0, 1, 3, 3, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #5;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses left, wanted 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
